// File: rtl/forward_stall_ctrl.sv
// Hazard unit for a 5-stage pipeline: load-use stall, branch flush, operand forwarding.
// Pipeline enables and clears are combinational; forward selects and counters are registered.
module forward_stall_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        R1_EX,
   input  logic        R1_MEM,
   input  logic        R2_EX,
   input  logic        R2_MEM,
   input  logic        EX_MemRead,
   input  logic        Branch_Taken,
   input  logic        Hold,
   output logic        PC_En,
   output logic        IFID_En,
   output logic        IDEX_En,
   output logic        IFID_Clr,
   output logic        IDEX_Clr,
   output logic [1:0]  R1_Fwd,
   output logic [1:0]  R2_Fwd,
   output logic [15:0] StallCnt,
   output logic [15:0] FlushCnt,
   output logic        state_dbg
);

   typedef enum logic {
      RUN  = 1'b0,
      LUSE = 1'b1
   } state_t;

   state_t      state, state_nxt;
   logic [1:0]  r1_fwd_nxt, r2_fwd_nxt;
   logic        stall_inc, flush_inc;
   logic        load_use;

   // EX-stage producer wins over MEM-stage producer: it is the younger write.
   function automatic logic [1:0] fwd_sel(input logic in_ex, input logic in_mem);
      if (in_ex)       fwd_sel = 2'b01;
      else if (in_mem) fwd_sel = 2'b10;
      else             fwd_sel = 2'b00;
   endfunction

   assign load_use  = EX_MemRead & (R1_EX | R2_EX);
   assign state_dbg = state;

   always_comb begin
      PC_En      = 1'b1;
      IFID_En    = 1'b1;
      IDEX_En    = 1'b1;
      IFID_Clr   = 1'b0;
      IDEX_Clr   = 1'b0;
      state_nxt  = RUN;
      r1_fwd_nxt = fwd_sel(R1_EX, R1_MEM);
      r2_fwd_nxt = fwd_sel(R2_EX, R2_MEM);
      stall_inc  = 1'b0;
      flush_inc  = 1'b0;

      if (rst) begin
         PC_En    = 1'b0;
         IFID_En  = 1'b0;
         IDEX_En  = 1'b0;
         IFID_Clr = 1'b1;
         IDEX_Clr = 1'b1;
      end else if (Hold) begin
         PC_En      = 1'b0;
         IFID_En    = 1'b0;
         IDEX_En    = 1'b0;
         state_nxt  = state;
         r1_fwd_nxt = R1_Fwd;
         r2_fwd_nxt = R2_Fwd;
      end else if (Branch_Taken) begin
         IFID_Clr   = 1'b1;
         IDEX_Clr   = 1'b1;
         r1_fwd_nxt = 2'b00;
         r2_fwd_nxt = 2'b00;
         flush_inc  = 1'b1;
      end else if (load_use && state == RUN) begin
         // Freeze PC and IF/ID, inject one bubble into ID/EX.
         PC_En      = 1'b0;
         IFID_En    = 1'b0;
         IDEX_Clr   = 1'b1;
         state_nxt  = LUSE;
         r1_fwd_nxt = 2'b00;
         r2_fwd_nxt = 2'b00;
         stall_inc  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         R1_Fwd   <= 2'b00;
         R2_Fwd   <= 2'b00;
         StallCnt <= 16'h0000;
         FlushCnt <= 16'h0000;
      end else begin
         state  <= state_nxt;
         R1_Fwd <= r1_fwd_nxt;
         R2_Fwd <= r2_fwd_nxt;
         if (stall_inc && StallCnt != 16'hFFFF) StallCnt <= StallCnt + 16'd1;
         if (flush_inc && FlushCnt != 16'hFFFF) FlushCnt <= FlushCnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_forward_stall_ctrl.sv
// Bench for forward_stall_ctrl: behavioural model feeds an expected-result queue
// that is popped after each clock edge; control outputs are checked before the edge.
module tb_forward_stall_ctrl;

   localparam int W = 37;  // {luse, r1_fwd, r2_fwd, stall_cnt, flush_cnt}

   logic        clk = 1'b0;
   logic        rst, R1_EX, R1_MEM, R2_EX, R2_MEM, EX_MemRead, Branch_Taken, Hold;
   logic        PC_En, IFID_En, IDEX_En, IFID_Clr, IDEX_Clr, state_dbg;
   logic [1:0]  R1_Fwd, R2_Fwd;
   logic [15:0] StallCnt, FlushCnt;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];

   logic        m_luse = 1'b0;
   logic [1:0]  m_r1 = 2'b00, m_r2 = 2'b00;
   logic [15:0] m_stall = 16'h0, m_flush = 16'h0;

   forward_stall_ctrl dut (
      .clk(clk), .rst(rst),
      .R1_EX(R1_EX), .R1_MEM(R1_MEM), .R2_EX(R2_EX), .R2_MEM(R2_MEM),
      .EX_MemRead(EX_MemRead), .Branch_Taken(Branch_Taken), .Hold(Hold),
      .PC_En(PC_En), .IFID_En(IFID_En), .IDEX_En(IDEX_En),
      .IFID_Clr(IFID_Clr), .IDEX_Clr(IDEX_Clr),
      .R1_Fwd(R1_Fwd), .R2_Fwd(R2_Fwd),
      .StallCnt(StallCnt), .FlushCnt(FlushCnt),
      .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation exceeded time budget, checks=%0d errors=%0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus, check control outputs, queue expected registered results.
   task automatic step(input logic i_rst, input logic r1e, input logic r1m, input logic r2e,
                       input logic r2m, input logic mr, input logic br, input logic hd);
      logic [4:0]   exp_c;
      logic         lu;
      logic [W-1:0] e;
      @(negedge clk);
      rst = i_rst; R1_EX = r1e; R1_MEM = r1m; R2_EX = r2e; R2_MEM = r2m;
      EX_MemRead = mr; Branch_Taken = br; Hold = hd;
      #1;
      lu = mr & (r1e | r2e);
      // {PC_En, IFID_En, IDEX_En, IFID_Clr, IDEX_Clr}
      if (i_rst)              exp_c = 5'b000_11;
      else if (hd)            exp_c = 5'b000_00;
      else if (br)            exp_c = 5'b111_11;
      else if (lu && !m_luse) exp_c = 5'b001_01;
      else                    exp_c = 5'b111_00;
      check("ctrl", 64'({PC_En, IFID_En, IDEX_En, IFID_Clr, IDEX_Clr}), 64'(exp_c));

      if (i_rst) begin
         m_luse = 1'b0; m_r1 = 2'b00; m_r2 = 2'b00; m_stall = 16'h0; m_flush = 16'h0;
      end else if (hd) begin
         m_luse = m_luse;
      end else if (br) begin
         m_luse = 1'b0; m_r1 = 2'b00; m_r2 = 2'b00;
         if (m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
      end else if (lu && !m_luse) begin
         m_luse = 1'b1; m_r1 = 2'b00; m_r2 = 2'b00;
         if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      end else begin
         m_luse = 1'b0;
         m_r1 = r1e ? 2'b01 : (r1m ? 2'b10 : 2'b00);
         m_r2 = r2e ? 2'b01 : (r2m ? 2'b10 : 2'b00);
      end
      exp_q.push_back({m_luse, m_r1, m_r2, m_stall, m_flush});

      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("queue", 64'(0), 64'(1));
      end else begin
         e = exp_q.pop_front();
         check("state",     64'(state_dbg), 64'(e[36]));
         check("r1_fwd",    64'(R1_Fwd),    64'(e[35:34]));
         check("r2_fwd",    64'(R2_Fwd),    64'(e[33:32]));
         check("stall_cnt", 64'(StallCnt),  64'(e[31:16]));
         check("flush_cnt", 64'(FlushCnt),  64'(e[15:0]));
      end
   endtask

   initial begin
      rst = 1'b1; R1_EX = 0; R1_MEM = 0; R2_EX = 0; R2_MEM = 0;
      EX_MemRead = 0; Branch_Taken = 0; Hold = 0;

      //    rst r1e r1m r2e r2m mr br hd
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 1, 0, 1, 1, 0);
      // EX forward without a load
      step(0, 1, 0, 0, 0, 0, 0, 0);
      check("fwd_ex_r1", 64'(R1_Fwd), 64'(2'b01));
      // load-use on R2, then MEM forward on R2
      step(0, 0, 0, 1, 0, 1, 0, 0);
      check("luse_stall", 64'(StallCnt), 64'(16'd1));
      step(0, 0, 0, 0, 1, 0, 0, 0);
      check("fwd_mem_r2", 64'(R2_Fwd), 64'(2'b10));
      // EX beats MEM
      step(0, 1, 1, 0, 0, 0, 0, 0);
      // branch beats load-use
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 1, 1, 0);
      check("br_flush", 64'({FlushCnt, StallCnt}), 64'({16'd1, 16'd0}));
      // load-use, hold 3 cycles in LUSE, release
      step(0, 1, 0, 0, 0, 1, 0, 0);
      step(0, 0, 1, 1, 0, 1, 0, 1);
      step(0, 1, 1, 0, 1, 1, 1, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 1, 0, 0);
      // branch while in LUSE
      step(0, 0, 0, 1, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 1, 1, 0);
      // load-use immediately after leaving LUSE, then reset mid-stall
      step(0, 0, 0, 1, 0, 1, 0, 0);
      step(1, 0, 0, 1, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0, 0);

      for (int i = 0; i < 500; i++) begin
         step(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      end

      // flush counter saturation, then reset clears everything
      step(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 65537; i++) step(0, 1, 0, 1, 0, 0, 1, 0);
      check("flush_sat", 64'(FlushCnt), 64'(16'hFFFF));
      step(0, 0, 0, 0, 0, 0, 1, 0);
      check("flush_hold_max", 64'(FlushCnt), 64'(16'hFFFF));
      step(0, 1, 0, 0, 1, 0, 0, 0);
      step(1, 1, 0, 1, 0, 0, 0, 0);
      check("rst_clear", 64'({StallCnt, FlushCnt, R1_Fwd, R2_Fwd}), 64'(0));
      step(0, 0, 1, 1, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
